// File: rtl/alu_op_sequencer.sv
// Command sequencer for the accumulator ALU: buffers commands, issues each for one cycle,
// waits for the accumulator to settle, returns it. Build macro OPSEQ_STATS_EN adds counters.
module alu_op_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CW         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_operand,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_opcode,
  output logic        rsp_err,
`ifdef OPSEQ_STATS_EN
  output logic [15:0] stat_issued,
  output logic [15:0] stat_illegal,
`endif
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  localparam logic [3:0] OpNop = 4'd0;
  localparam logic [3:0] OpRst = 4'd1;
  localparam logic [3:0] OpAdd = 4'd5;
  localparam logic [3:0] OpAnd = 4'd9;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  logic [3:0]    fifo_op   [DEPTH];
  logic [15:0]   fifo_opnd [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          in_reset_q;

  state_e        state_q;
  logic [CW-1:0] settle_q;
  logic [3:0]    cur_op_q;

  logic          push;
  logic          pop;
  logic          head_legal;
  logic [3:0]    head_op;
  logic [15:0]   head_opnd;

  // Ready comes only from registered state so it never depends on a same-cycle pop.
  assign cmd_ready = !in_reset_q && (count_q != FullCnt);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign head_op   = fifo_op[rd_ptr_q];
  assign head_opnd = fifo_opnd[rd_ptr_q];
  assign busy      = (state_q != StIdle) || (count_q != '0);

  always_comb begin
    head_legal = 1'b0;
    case (head_op)
      OpNop, OpRst, OpAdd, OpAnd: head_legal = 1'b1;
      default:                    head_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_q]   <= cmd_opcode;
      fifo_opnd[wr_ptr_q] <= cmd_operand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_reset_q <= 1'b1;
    end else begin
      in_reset_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // The ALU accumulator has no reset of its own: drive RESET into it while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      alu_opcode  <= OpRst;
      alu_operand <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_opcode  <= '0;
      rsp_err     <= 1'b0;
      settle_q    <= '0;
      cur_op_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          alu_opcode <= OpNop;
          if (pop) begin
            cur_op_q <= head_op;
            if (head_legal) begin
              state_q     <= StIssue;
              alu_opcode  <= head_op;
              alu_operand <= head_opnd;
            end else begin
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_result <= alu_result;
              rsp_opcode <= head_op;
              rsp_err    <= 1'b1;
            end
          end
        end
        StIssue: begin
          alu_opcode <= OpNop;
          settle_q   <= CW'(SETTLE_CYC - 1);
          state_q    <= StWait;
        end
        StWait: begin
          if (settle_q == '0) begin
            state_q    <= StResp;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_opcode <= cur_op_q;
            rsp_err    <= 1'b0;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef OPSEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else if (pop) begin
      if (head_legal) stat_issued  <= stat_issued + 16'd1;
      else            stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table plus scoreboard, with a behavioural accumulator ALU.
module tb_alu_op_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned NVEC = 14;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] opnd;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_operand;
  logic [31:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_opcode;
  logic        rsp_err;
  logic        busy;
`ifdef OPSEQ_STATS_EN
  logic [15:0] stat_issued, stat_illegal;
`endif

  logic        b_cmd_valid, b_cmd_ready;
  logic [3:0]  b_cmd_opcode;
  logic [15:0] b_cmd_operand;
  logic [3:0]  b_alu_opcode;
  logic [15:0] b_alu_operand;
  logic [31:0] b_alu_result;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_result;
  logic [3:0]  b_rsp_opcode;
  logic        b_rsp_err;
  logic        b_busy;
`ifdef OPSEQ_STATS_EN
  logic [15:0] b_stat_issued, b_stat_illegal;
`endif

  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE), .CW(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .alu_opcode(alu_opcode),
    .alu_operand(alu_operand), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_opcode(rsp_opcode),
    .rsp_err(rsp_err),
`ifdef OPSEQ_STATS_EN
    .stat_issued(stat_issued), .stat_illegal(stat_illegal),
`endif
    .busy(busy)
  );

  alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE_CYC(3), .CW(3)) dut_slow (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_opcode(b_cmd_opcode), .cmd_operand(b_cmd_operand), .alu_opcode(b_alu_opcode),
    .alu_operand(b_alu_operand), .alu_result(b_alu_result), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result), .rsp_opcode(b_rsp_opcode),
    .rsp_err(b_rsp_err),
`ifdef OPSEQ_STATS_EN
    .stat_issued(b_stat_issued), .stat_illegal(b_stat_illegal),
`endif
    .busy(b_busy)
  );

  // Behavioural ALU: accumulator starts as garbage to prove the sequencer clears it.
  logic [31:0] acc = 32'hDEAD_BEEF;
  logic [31:0] b_acc = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    case (alu_opcode)
      4'd1: acc <= 32'h0;
      4'd5: acc <= acc + {16'h0, alu_operand};
      4'd9: acc <= acc & {16'h0, alu_operand};
      default: ;
    endcase
    case (b_alu_opcode)
      4'd1: b_acc <= 32'h0;
      4'd5: b_acc <= b_acc + {16'h0, b_alu_operand};
      4'd9: b_acc <= b_acc & {16'h0, b_alu_operand};
      default: ;
    endcase
  end
  assign alu_result = acc;
  assign b_alu_result = b_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_bad = 0;
  int   bad_issue = 0;
  bit   lat_armed = 0;
  int   lat_cyc = -1;
  exp_t sb[$];
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got result %h, expected no response", rsp_result);
        end else begin
          e = sb.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (lat_armed && rsp_valid) begin
        lat_cyc = cyc;
        lat_armed = 0;
      end
      if (!(alu_opcode inside {4'd0, 4'd1, 4'd5, 4'd9})) bad_issue++;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] d, input int bound,
                      output bit ok);
    cmd_valid = 1'b1;
    cmd_opcode = op;
    cmd_operand = d;
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    int t_accept;
    int n_acc;
    int n_legal;
    int n_illegal;
    int lat2;

    vecs[0]  = '{4'd5, 16'h0001, 32'h0000_0001, 1'b0};
    vecs[1]  = '{4'd5, 16'h0001, 32'h0000_0002, 1'b0};
    vecs[2]  = '{4'd5, 16'h0001, 32'h0000_0003, 1'b0};
    vecs[3]  = '{4'd1, 16'h0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{4'd5, 16'h000F, 32'h0000_000F, 1'b0};
    vecs[5]  = '{4'd0, 16'h0000, 32'h0000_000F, 1'b0};
    vecs[6]  = '{4'd9, 16'h000B, 32'h0000_000B, 1'b0};
    vecs[7]  = '{4'd1, 16'h0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{4'd5, 16'h0005, 32'h0000_0005, 1'b0};
    vecs[9]  = '{4'd3, 16'hFFFF, 32'h0000_0005, 1'b1};
    vecs[10] = '{4'hF, 16'h1234, 32'h0000_0005, 1'b1};
    vecs[11] = '{4'd5, 16'hFFFF, 32'h0001_0004, 1'b0};
    vecs[12] = '{4'd5, 16'hFFFF, 32'h0002_0003, 1'b0};
    vecs[13] = '{4'd9, 16'h0000, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_operand = '0; rsp_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_opcode = '0; b_cmd_operand = '0; b_rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_alu_opcode", 32'(alu_opcode), 32'd1);
    check("reset_alu_operand", 32'(alu_operand), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_alu_opcode", 32'(alu_opcode), 32'd0);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Main vector table, rsp_ready held high.
    rsp_ready = 1'b1;
    lat_armed = 1'b1;
    t_accept = 0;
    n_legal = 0;
    n_illegal = 0;
    for (int i = 0; i < int'(NVEC); i++) begin
      send(vecs[i].op, vecs[i].opnd, 40, ok);
      if (i == 0) t_accept = cyc;
      check("cmd_accept", 32'(ok), 32'd1);
      if (ok) sb.push_back('{vecs[i].res, vecs[i].op, vecs[i].err});
      if (vecs[i].op inside {4'd0, 4'd1, 4'd5, 4'd9}) n_legal++;
      else n_illegal++;
    end
    drain("table_drain");
    check("first_rsp_latency", 32'(lat_cyc - t_accept), 32'(SETTLE + 2));
`ifdef OPSEQ_STATS_EN
    check("stat_issued", 32'(stat_issued), 32'(n_legal));
    check("stat_illegal", 32'(stat_illegal), 32'(n_illegal));
`endif
    @(posedge clk);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: one command popped and held in RESP, DEPTH more buffered, then full.
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      send(4'd5, 16'h0001, (i == int'(DEPTH) + 1) ? 6 : 20, ok);
      if (ok) begin
        n_acc++;
        sb.push_back('{32'(n_acc), 4'd5, 1'b0});
      end
    end
    check("bp_accepts", 32'(n_acc), 32'(DEPTH + 1));
    @(negedge clk);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    check("bp_rsp_result_held", rsp_result, 32'd1);
    check("bp_rsp_opcode_held", 32'(rsp_opcode), 32'd5);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain("bp_drain");
    @(posedge clk);
    #1;

    // Reset while the ADD 7 is in WAIT: no response, accumulator cleared.
    send(4'd5, 16'h0007, 20, ok);
    check("midrst_accept", 32'(ok), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu_opcode", 32'(alu_opcode), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(4'd0, 16'h0000, 20, ok);
    if (ok) sb.push_back('{32'h0, 4'd0, 1'b0});
    check("midrst_noop_accept", 32'(ok), 32'd1);
    drain("midrst_drain");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_final_busy", 32'(busy), 32'd0);

    // SETTLE_CYC=3 instance, idle since the last reset.
    @(posedge clk);
    #1;
    b_cmd_valid = 1'b1;
    b_cmd_opcode = 4'd5;
    b_cmd_operand = 16'h0002;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (b_cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    b_cmd_valid = 1'b0;
    t_accept = cyc;
    check("slow_accept", 32'(ok), 32'd1);
    lat2 = -1;
    for (int k = 0; k < 20 && lat2 < 0; k++) begin
      @(negedge clk);
      if (b_rsp_valid) lat2 = cyc - t_accept;
    end
    check("slow_latency", 32'(lat2), 32'd5);
    check("slow_rsp_result", b_rsp_result, 32'h2);
    check("slow_rsp_opcode", 32'(b_rsp_opcode), 32'd5);
    check("slow_rsp_err", 32'(b_rsp_err), 32'd0);

    check("no_illegal_issue", 32'(bad_issue), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command sequencer in front of the accumulator ALU breadboard: NO-OP=0, RESET=1, ADD=5, AND=9.
- Buffers opcode/operand commands from a requester in a small FIFO.
- Issues each command to the ALU for exactly one clock, then holds the ALU in NO-OP while the accumulator settles.
- Returns the resulting accumulator value on a valid/ready response channel and clears the accumulator on reset, since the ALU accumulator flops have no reset.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2
SETTLE_CYC, 1, NO-OP cycles after issue before sampling alu_result; minimum 1
CW, 3, width of the settle counter; must hold SETTLE_CYC

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= !full)
cmd_opcode  input  4  ALU opcode
cmd_operand  input  16  operand A for ALU
alu_opcode  output  4  registered opcode to ALU
alu_operand  output  16  registered operand to ALU input A
alu_result  input  32  ALU output C (equals accumulator while opcode=NO-OP)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_result  output  32  accumulator value after the command
rsp_opcode  output  4  opcode the response belongs to
rsp_err  output  1  command was illegal, not issued
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst high at an edge):
  - FIFO emptied; state=IDLE.
  - alu_opcode=4'b0001 (RESET) and alu_operand=0, so the accumulator clears while rst is held.
  - rsp_valid=0, rsp_result=0, rsp_opcode=0, rsp_err=0, cmd_ready=0; busy=0.
  - First edge after rst deasserts: alu_opcode=0.
- Reset mid-operation: any in-flight command and any pending response are discarded; no response is produced.
- FIFO:
  - Push on cmd_valid&&cmd_ready. Pop only on the IDLE->ISSUE or IDLE->RESP transition.
  - cmd_ready=!full, computed from registered count only. No push when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH. Count is 0..DEPTH.
- Legal opcodes: 0, 1, 5, 9. All others are illegal.
- States: IDLE, ISSUE, WAIT, RESP.
  - IDLE: alu_opcode=0. If FIFO non-empty, pop the head.
    - Legal head -> ISSUE; alu_opcode/alu_operand loaded from the head.
    - Illegal head -> RESP with rsp_err=1, rsp_result=current alu_result, ALU untouched.
  - ISSUE (exactly 1 cycle): the ALU executes; the accumulator updates at the edge leaving ISSUE. alu_opcode returns to 0 at that edge. Go to WAIT with counter=SETTLE_CYC-1.
  - WAIT: decrement; at 0, capture rsp_result=alu_result, rsp_opcode, rsp_err=0, and go to RESP.
  - RESP: rsp_valid=1, all rsp_* stable until rsp_valid&&rsp_ready, then -> IDLE. No new command is issued while in RESP.
- Latency:
  - Command accepted at edge E0 into an empty, idle sequencer: ISSUE entered at E1; rsp_valid rises at E(SETTLE_CYC+2), i.e. E3 for default.
  - Throughput: one command per SETTLE_CYC+3 cycles with rsp_ready tied high.
- NO-OP commands are issued like others; the response returns the unchanged accumulator.
- Width: responses carry the full 32-bit alu_result. The sequencer performs no arithmetic.

Optional Feature:
- Macro OPSEQ_STATS_EN.
- Defined: adds outputs stat_issued[15:0] (counts ISSUE entries) and stat_illegal[15:0] (counts illegal pops).
  - Both counters wrap at 16'hFFFF->0 and clear on rst.
  - Both increment in the same cycle as the corresponding pop.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- rst 2 cycles, then ADD 1 three times, rsp_ready=1 -> alu_opcode=1 during reset; responses 32'h1, 32'h2, 32'h3 with rsp_opcode=5, rsp_err=0; first rsp_valid exactly 3 edges after first accept.
- RESET, ADD 16'h000F, NO-OP, AND 16'h000B -> responses 0, 32'hF, 32'hF, 32'hB.
- ADD 5, then opcode 4'h3 operand 16'hFFFF -> second response rsp_err=1, rsp_result=32'h5, alu_opcode never 3; with OPSEQ_STATS_EN: stat_illegal=1, stat_issued=1.
- rsp_ready=0, push DEPTH+2 ADD 1 commands -> cmd_ready drops after DEPTH+1 accepts (one popped, DEPTH buffered); rsp_* held stable; release rsp_ready -> responses 1..DEPTH+1 in order.
- rst asserted while in WAIT after ADD 7 -> no response; accumulator reads 0 via a following NO-OP response; FIFO empty, busy=0.
- SETTLE_CYC=3 build, single ADD 2 after reset -> rsp_valid at E5, result 32'h2.
